// File: rtl/lc3_pkg.sv
// LC-3 decode shared types: opcodes, execute control word, selector codes.
// Imported by the decode interface, control decoder and decode stage.
package lc3_pkg;

   localparam int DW   = 16;
   localparam int EC_W = 6;
   localparam int WC_W = 2;

   typedef enum logic [3:0] {
      OP_BR   = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_LD   = 4'b0010,
      OP_ST   = 4'b0011,
      OP_JSR  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_LDR  = 4'b0110,
      OP_STR  = 4'b0111,
      OP_RTI  = 4'b1000,
      OP_NOT  = 4'b1001,
      OP_LDI  = 4'b1010,
      OP_STI  = 4'b1011,
      OP_JMP  = 4'b1100,
      OP_RES  = 4'b1101,
      OP_LEA  = 4'b1110,
      OP_TRAP = 4'b1111
   } opcode_e;

   typedef struct packed {
      logic [1:0] alu;
      logic [1:0] pcsel1;
      logic       pcsel2;
      logic       op2;
   } e_control_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b01;
   localparam logic [1:0] ALU_NOT = 2'b10;

   localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
   localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
   localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
   localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

   localparam logic [WC_W-1:0] WC_ALU = 2'd0;
   localparam logic [WC_W-1:0] WC_MEM = 2'd1;
   localparam logic [WC_W-1:0] WC_PC  = 2'd2;

endpackage

// File: rtl/lc3_decode_if.sv
// decode_in bus from fetch/controller plus the registered decode outputs.
// master drives fetch-side inputs; slave is the decode stage.
interface lc3_decode_if;
   import lc3_pkg::*;

   logic            en_decode;
   logic [DW-1:0]   instr_dout;
   logic [DW-1:0]   npc_in;
   logic [2:0]      psr;

   logic [DW-1:0]   IR;
   logic [DW-1:0]   npc_out;
   logic [2:0]      psr_out;
   logic [EC_W-1:0] E_Control;
   logic [WC_W-1:0] W_Control;
   logic            Mem_Control;
   logic            illegal_op;
   logic            dec_valid;

   modport master (
      output en_decode, instr_dout, npc_in, psr,
      input  IR, npc_out, psr_out, E_Control, W_Control,
      input  Mem_Control, illegal_op, dec_valid
   );

   modport slave (
      input  en_decode, instr_dout, npc_in, psr,
      output IR, npc_out, psr_out, E_Control, W_Control,
      output Mem_Control, illegal_op, dec_valid
   );

endinterface

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder producing execute/writeback/memory controls.
// Any opcode the datapath cannot run yields zero controls and illegal=1.
module lc3_decode_ctrl
   import lc3_pkg::*;
(
   input  opcode_e         op,
   input  logic            instr5,
   output e_control_t      e_ctrl,
   output logic [WC_W-1:0] w_ctrl,
   output logic            mem_ctrl,
   output logic            illegal
);

   always_comb begin
      e_ctrl   = '0;
      w_ctrl   = WC_ALU;
      mem_ctrl = 1'b0;
      illegal  = 1'b0;
      case (op)
         OP_ADD: begin
            e_ctrl.alu = ALU_ADD;
            e_ctrl.op2 = ~instr5;
         end
         OP_AND: begin
            e_ctrl.alu = ALU_AND;
            e_ctrl.op2 = ~instr5;
         end
         OP_NOT: e_ctrl.alu = ALU_NOT;
         OP_BR: begin
            e_ctrl.pcsel1 = PCSEL1_OFF9;
            e_ctrl.pcsel2 = 1'b1;
         end
         OP_JMP: e_ctrl.pcsel1 = PCSEL1_ZERO;
         OP_LD, OP_LDI: begin
            e_ctrl.pcsel1 = PCSEL1_OFF9;
            e_ctrl.pcsel2 = 1'b1;
            w_ctrl        = WC_MEM;
            mem_ctrl      = (op == OP_LDI);
         end
         OP_LDR: begin
            e_ctrl.pcsel1 = PCSEL1_OFF6;
            w_ctrl        = WC_MEM;
         end
         OP_ST, OP_STI: begin
            e_ctrl.pcsel1 = PCSEL1_OFF9;
            e_ctrl.pcsel2 = 1'b1;
            mem_ctrl      = (op == OP_STI);
         end
         OP_STR: e_ctrl.pcsel1 = PCSEL1_OFF6;
         OP_LEA: begin
            e_ctrl.pcsel1 = PCSEL1_OFF9;
            e_ctrl.pcsel2 = 1'b1;
            w_ctrl        = WC_PC;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: captures instruction/NPC/PSR on en_decode and
// registers the derived control words; dec_valid marks each capture.
module lc3_decode
   import lc3_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   lc3_decode_if.slave  dec_if
);

   logic [DW-1:0]   ir_q, ir_d;
   logic [DW-1:0]   npc_q, npc_d;
   logic [2:0]      psr_q, psr_d;
   e_control_t      e_q, e_d;
   logic [WC_W-1:0] w_q, w_d;
   logic            mem_q, mem_d;
   logic            ill_q, ill_d;
   logic            valid_q, valid_d;

   e_control_t      e_c;
   logic [WC_W-1:0] w_c;
   logic            mem_c;
   logic            ill_c;

   lc3_decode_ctrl u_ctrl (
      .op       (opcode_e'(dec_if.instr_dout[15:12])),
      .instr5   (dec_if.instr_dout[5]),
      .e_ctrl   (e_c),
      .w_ctrl   (w_c),
      .mem_ctrl (mem_c),
      .illegal  (ill_c)
   );

   always_comb begin
      ir_d    = ir_q;
      npc_d   = npc_q;
      psr_d   = psr_q;
      e_d     = e_q;
      w_d     = w_q;
      mem_d   = mem_q;
      ill_d   = ill_q;
      valid_d = dec_if.en_decode;
      if (dec_if.en_decode) begin
         ir_d  = dec_if.instr_dout;
         npc_d = dec_if.npc_in;
         psr_d = dec_if.psr;
         e_d   = e_c;
         w_d   = w_c;
         mem_d = mem_c;
         ill_d = ill_c;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q    <= '0;
         npc_q   <= '0;
         psr_q   <= '0;
         e_q     <= '0;
         w_q     <= '0;
         mem_q   <= 1'b0;
         ill_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         npc_q   <= npc_d;
         psr_q   <= psr_d;
         e_q     <= e_d;
         w_q     <= w_d;
         mem_q   <= mem_d;
         ill_q   <= ill_d;
         valid_q <= valid_d;
      end
   end

   assign dec_if.IR          = ir_q;
   assign dec_if.npc_out     = npc_q;
   assign dec_if.psr_out     = psr_q;
   assign dec_if.E_Control   = e_q;
   assign dec_if.W_Control   = w_q;
   assign dec_if.Mem_Control = mem_q;
   assign dec_if.illegal_op  = ill_q;
   assign dec_if.dec_valid   = valid_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: expected outputs queued at drive time,
// popped and checked one cycle later.
module tb_lc3_decode;
   import lc3_pkg::*;

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] npc;
      logic [2:0]  psr;
      logic [5:0]  e;
      logic [1:0]  w;
      logic        m;
      logic        ill;
      logic        v;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   exp_t mdl;

   lc3_decode_if dec_if ();

   lc3_decode dut (
      .clock  (clock),
      .reset  (reset),
      .dec_if (dec_if.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference table written directly from the opcode rows
   function automatic logic [9:0] ref_dec(input logic [3:0] op,
                                          input logic b5);
      case (op)
         4'b0001: return {2'b00, 2'b00, 1'b0, ~b5, 2'd0, 1'b0, 1'b0};
         4'b0101: return {2'b01, 2'b00, 1'b0, ~b5, 2'd0, 1'b0, 1'b0};
         4'b1001: return {6'b100000, 2'd0, 1'b0, 1'b0};
         4'b0000: return {6'b000110, 2'd0, 1'b0, 1'b0};
         4'b1100: return {6'b001100, 2'd0, 1'b0, 1'b0};
         4'b0010: return {6'b000110, 2'd1, 1'b0, 1'b0};
         4'b1010: return {6'b000110, 2'd1, 1'b1, 1'b0};
         4'b0110: return {6'b001000, 2'd1, 1'b0, 1'b0};
         4'b0011: return {6'b000110, 2'd0, 1'b0, 1'b0};
         4'b1011: return {6'b000110, 2'd0, 1'b1, 1'b0};
         4'b0111: return {6'b001000, 2'd0, 1'b0, 1'b0};
         4'b1110: return {6'b000110, 2'd2, 1'b0, 1'b0};
         default: return {6'b000000, 2'd0, 1'b0, 1'b1};
      endcase
   endfunction

   task automatic step(input logic rst, input logic en,
                       input logic [15:0] instr, input logic [15:0] npc,
                       input logic [2:0] psr);
      exp_t       got;
      exp_t       exp;
      logic [9:0] d;
      @(negedge clock);
      reset             = rst;
      dec_if.en_decode  = en;
      dec_if.instr_dout = instr;
      dec_if.npc_in     = npc;
      dec_if.psr        = psr;
      if (rst) begin
         mdl = '0;
      end else if (en) begin
         d       = ref_dec(instr[15:12], instr[5]);
         mdl.ir  = instr;
         mdl.npc = npc;
         mdl.psr = psr;
         mdl.e   = d[9:4];
         mdl.w   = d[3:2];
         mdl.m   = d[1];
         mdl.ill = d[0];
         mdl.v   = 1'b1;
      end else begin
         mdl.v = 1'b0;
      end
      sb_q.push_back(mdl);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         exp = sb_q.pop_front();
         got = '{ir: dec_if.IR, npc: dec_if.npc_out, psr: dec_if.psr_out,
                 e: dec_if.E_Control, w: dec_if.W_Control,
                 m: dec_if.Mem_Control, ill: dec_if.illegal_op,
                 v: dec_if.dec_valid};
         chk("IR", {16'h0, got.ir}, {16'h0, exp.ir});
         chk("npc_out", {16'h0, got.npc}, {16'h0, exp.npc});
         chk("psr_out", {29'h0, got.psr}, {29'h0, exp.psr});
         chk("E_Control", {26'h0, got.e}, {26'h0, exp.e});
         chk("W_Control", {30'h0, got.w}, {30'h0, exp.w});
         chk("Mem_Control", {31'h0, got.m}, {31'h0, exp.m});
         chk("illegal_op", {31'h0, got.ill}, {31'h0, exp.ill});
         chk("dec_valid", {31'h0, got.v}, {31'h0, exp.v});
      end
   endtask

   initial begin
      mdl               = '0;
      reset             = 1'b1;
      dec_if.en_decode  = 1'b0;
      dec_if.instr_dout = '0;
      dec_if.npc_in     = '0;
      dec_if.psr        = '0;

      step(1'b1, 1'b1, 16'h1283, 16'h3001, 3'b010);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 3'b000);
      step(1'b0, 1'b1, 16'h1283, 16'h3001, 3'b010);
      step(1'b0, 1'b1, 16'h12A5, 16'h3002, 3'b001);
      step(1'b0, 1'b1, 16'h5020, 16'h3003, 3'b100);
      step(1'b0, 1'b1, 16'hA5FF, 16'h3004, 3'b010);
      step(1'b0, 1'b1, 16'h6642, 16'h3005, 3'b001);
      step(1'b0, 1'b1, 16'hE1F0, 16'h3006, 3'b100);
      step(1'b0, 1'b0, 16'h1283, 16'h4000, 3'b111);
      step(1'b0, 1'b0, 16'hF025, 16'h4001, 3'b011);
      step(1'b0, 1'b0, 16'h5020, 16'h4002, 3'b101);
      step(1'b0, 1'b1, 16'hF025, 16'h3007, 3'b010);
      step(1'b0, 1'b1, 16'h9A3F, 16'h3008, 3'b001);

      for (int op = 0; op < 16; op++) begin
         step(1'b0, 1'b1, {op[3:0], 12'h0A5 ^ 12'(op * 37)},
              16'(16'h5000 + op), 3'(op));
      end

      // Mid-stream reset discards the capture that coincides with it
      step(1'b0, 1'b1, 16'h2E10, 16'h6000, 3'b100);
      step(1'b1, 1'b1, 16'hB1C3, 16'h6001, 3'b010);
      step(1'b0, 1'b0, 16'hB1C3, 16'h6002, 3'b010);
      step(1'b0, 1'b1, 16'hB1C3, 16'h6003, 3'b010);

      for (int i = 0; i < 48; i++) begin
         step(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
              16'($urandom), 16'($urandom), 3'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
